// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI-style memory responder with a fixed-latency, in-order
// response pipeline, an outstanding-request limiter and a backdoor preload port.
//
// Ports:
//   clk_i, rst_i          clock (rising edge) and asynchronous active-high reset
//   req_i / gnt_o         request handshake; gnt_o is combinational
//   addr_i, we_i, be_i,   request payload, sampled only at the accept edge
//   wdata_i
//   rvalid_o, rdata_o     one-cycle response pulse, RD_LATENCY cycles after accept
//   gnt_stall_i           external grant suppression (does not touch responses)
//   pl_we_i, pl_addr_i,   full-word backdoor write into the memory array
//   pl_wdata_i
//   outstanding_o         granted-but-unanswered request count
module obi_mem_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned DEPTH           = 256,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        gnt_stall_i,
  input  logic        pl_we_i,
  input  logic [31:0] pl_addr_i,
  input  logic [31:0] pl_wdata_i,
  output logic [2:0]  outstanding_o
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [31:0] OOR_DATA = 32'hBAD0_BAD0;
  localparam logic [2:0]  MAX_OUT  = 3'(MAX_OUTSTANDING);

  // Elaboration-time parameter range checks
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("obi_mem_responder: RD_LATENCY must be in 1..4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_outstanding
    $error("obi_mem_responder: MAX_OUTSTANDING must be in 1..4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("obi_mem_responder: DEPTH must be a power of two >= 2");
  end

  logic [31:0] mem [DEPTH];

  logic [31:0]      bus_off;
  logic             bus_hit;
  logic [IDX_W-1:0] bus_idx;
  logic [31:0]      pl_off;
  logic             pl_hit;
  logic [IDX_W-1:0] pl_idx;
  logic             accept;
  logic [31:0]      rd_word;
  logic [31:0]      rsp_word;

  logic [RD_LATENCY-1:0]        pipe_valid;
  logic [RD_LATENCY-1:0][31:0]  pipe_data;

  // Address decode: offset relative to BASE_ADDR, byte offset bits ignored
  assign bus_off = addr_i - BASE_ADDR;
  assign bus_hit = (bus_off < SPAN);
  assign bus_idx = bus_off[IDX_W+1:2];

  assign pl_off  = pl_addr_i - BASE_ADDR;
  assign pl_hit  = (pl_off < SPAN);
  assign pl_idx  = pl_off[IDX_W+1:2];

  // Grant is held off during reset, on stall, and while the limit is reached
  assign gnt_o  = ~rst_i & req_i & ~gnt_stall_i & (outstanding_o < MAX_OUT);
  assign accept = gnt_o;

  // Load data captured at the accept edge; stores respond with zero
  assign rd_word  = bus_hit ? mem[bus_idx] : OOR_DATA;
  assign rsp_word = we_i ? 32'h0 : rd_word;

  // Memory array: preload first, bus store lanes override on the same word
  always_ff @(posedge clk_i) begin
    if (pl_we_i && pl_hit) begin
      mem[pl_idx] <= pl_wdata_i;
    end
    if (accept && we_i && bus_hit) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem[bus_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response shift register; idle stages carry zero data so rdata_o is 0 when not valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_data  <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= accept ? rsp_word : 32'h0;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid[RD_LATENCY-1];
  assign rdata_o  = pipe_data[RD_LATENCY-1];

  // Outstanding counter: +1 on accept, -1 on response, hold when both
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_o <= 3'd0;
    end else begin
      unique case ({accept, rvalid_o})
        2'b10:   outstanding_o <= outstanding_o + 3'd1;
        2'b01:   outstanding_o <= outstanding_o - 3'd1;
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder: randomized and directed stimulus with a scoreboard.
// The driver predicts grants, outstanding count and response words from a
// word-array memory model; a separate monitor matches every response slot.
module tb_obi_mem_responder;

  localparam int unsigned LAT   = 3;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        gnt_stall_i = 1'b0;
  logic        pl_we_i = 1'b0;
  logic [31:0] pl_addr_i = '0;
  logic [31:0] pl_wdata_i = '0;
  logic [2:0]  outstanding_o;

  obi_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .gnt_stall_i(gnt_stall_i), .pl_we_i(pl_we_i), .pl_addr_i(pl_addr_i),
    .pl_wdata_i(pl_wdata_i), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [31:0] mem_m [DEPTH];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  bit          last_acc;
  int          peak;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_chk++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint la, lb;
    la = longint'({32'h0, a});
    lb = longint'({32'h0, BASE});
    return (la >= lb) && (la < lb + 4 * longint'(DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  // One bus cycle: drive at the falling edge, then predict and check handshake
  task automatic cyc_do(input bit rst, input bit req, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit stall,
                        input bit plwe, input logic [31:0] pla, input logic [31:0] pld);
    logic [31:0] rd;
    int          out_m;
    bit          g;
    exp_t        e;
    @(negedge clk);
    rst_i = rst; req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    gnt_stall_i = stall; pl_we_i = plwe; pl_addr_i = pla; pl_wdata_i = pld;
    #1;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end
    // a request accepted in cycle a stays outstanding through cycle a+LAT
    while (acc_q.size() > 0 && acc_q[0] < cyc - int'(LAT)) void'(acc_q.pop_front());
    out_m = acc_q.size();
    g = !rst && req && !stall && (out_m < int'(MAXO));
    chk("gnt", 32'(gnt_o), 32'(g));
    chk("outstanding", 32'(outstanding_o), 32'(out_m));
    if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
    rd = in_rng(addr) ? mem_m[widx(addr)] : 32'hBAD0_BAD0;
    if (plwe && in_rng(pla)) mem_m[widx(pla)] = pld;
    if (g) begin
      acc_q.push_back(cyc);
      e.data = we ? 32'h0 : rd;
      e.due  = cyc + int'(LAT);
      exp_q.push_back(e);
      if (we && in_rng(addr)) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) mem_m[widx(addr)][8*k +: 8] = wdata[8*k +: 8];
        end
      end
    end
    last_acc = g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_do(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    cyc_do(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, a, d);
  endtask

  // Hold req until the model predicts acceptance
  task automatic issue(input bit we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] d);
    for (int t = 0; t < 20; t++) begin
      cyc_do(0, 1, we, be, a, d, 0, 0, 32'h0, 32'h0);
      if (last_acc) return;
    end
    fail("issue_timeout", "request never granted");
  endtask

  // Monitor: every cycle, compare rvalid/rdata against the head of the scoreboard
  initial begin : monitor
    exp_t e;
    bit   ev;
    forever begin
      @(negedge clk);
      #2;
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rvalid", 32'(rvalid_o), 32'(ev));
      if (rvalid_o && ev) begin
        e = exp_q.pop_front();
        chk("rdata", rdata_o, e.data);
      end else if (!rvalid_o) begin
        chk("rdata_idle", rdata_o, 32'h0);
        if (ev) void'(exp_q.pop_front());
      end
    end
  end

  initial begin : stim
    logic [31:0] a, pa, d;
    bit          rq, st, pw, wr;
    logic [3:0]  be;

    // Reset with req asserted: no grant, no response, counter at zero
    for (int i = 0; i < 3; i++) cyc_do(1, 1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(1);

    // Fill memory through the backdoor so every word is defined
    for (int i = 0; i < int'(DEPTH); i++) preload(BASE + 32'(i * 4), $urandom);

    // Preloaded word read back
    preload(32'h0, 32'h0000_000A);
    issue(0, 4'h0, 32'h0, 32'h0);
    idle(LAT + 1);

    // Partial store over preload, then load
    preload(32'h4, 32'h1111_1111);
    issue(1, 4'b0101, 32'h4, 32'hAABB_CCDD);
    issue(0, 4'h0, 32'h4, 32'h0);
    idle(LAT + 1);
    chk("partial_store_word", mem_m[1], 32'h11BB_11DD);

    // Four loads with req held: limiter throttles grants
    peak = 0;
    issue(0, 4'h0, 32'h0, 32'h0);
    issue(0, 4'h0, 32'h4, 32'h0);
    issue(0, 4'h0, 32'h8, 32'h0);
    issue(0, 4'h0, 32'hC, 32'h0);
    idle(LAT + 1);
    chk("peak_outstanding", 32'(peak), 32'(MAXO));

    // Out-of-range load and dropped out-of-range store
    issue(0, 4'h0, 32'h400, 32'h0);
    issue(1, 4'hF, 32'h400, 32'hFFFF_FFFF);
    issue(0, 4'h0, 32'h0, 32'h0);
    issue(0, 4'h0, 32'hFFFF_FFFC, 32'h0);
    idle(LAT + 1);

    // Same-edge preload and store to one word
    cyc_do(0, 1, 1, 4'b1010, 32'h8, 32'hDEAD_BEEF, 0, 1, 32'h8, 32'h5566_7788);
    chk("collision_accept", 32'(last_acc), 32'd1);
    issue(0, 4'h0, 32'h9, 32'h0);
    idle(LAT + 1);
    chk("collision_word", mem_m[2], 32'hDE66_BE88);

    // Stall for 5 cycles with an earlier response still in flight
    issue(0, 4'h0, 32'h4, 32'h0);
    for (int i = 0; i < 5; i++) cyc_do(0, 1, 0, 4'h0, 32'h10, 32'h0, 1, 0, 32'h0, 32'h0);
    cyc_do(0, 1, 0, 4'h0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("gnt_after_stall", 32'(gnt_o), 32'd1);
    idle(LAT + 1);

    // Reset with two loads pending: both dropped, memory kept
    issue(0, 4'h0, 32'h0, 32'h0);
    issue(0, 4'h0, 32'h4, 32'h0);
    cyc_do(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    cyc_do(1, 1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(LAT + 2);
    issue(0, 4'h0, 32'h0, 32'h0);
    issue(0, 4'h0, 32'h8, 32'h0);
    idle(LAT + 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rq = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 1) == 1);
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 4095)) * 32'd4;
      else a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      st = ($urandom_range(0, 4) == 0);
      pw = ($urandom_range(0, 5) == 0);
      pa = ($urandom_range(0, 2) == 0) ? a : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      d  = $urandom;
      cyc_do(0, rq, wr, be, a, d, st, pw, pa, $urandom);
    end
    idle(LAT + 2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
